credit_flowcontrol: RTL and testbench
=====================================

# credit_flowcontrol

Parametrised credit-based flow control between the input FIFOs and the output ports of a mesh router. Each output port has a credit counter that tracks the free slots in the downstream input FIFO. The counter is decremented when a flit is sent and incremented when the downstream router returns a credit. `ready_out[p]` is asserted only when port `p` is selected by routing and at least one credit remains, so flits are never pushed into a full downstream buffer. The block generalises the single-bit ready gating to NPORTS ports, configurable buffer depth, registered credit state and sticky protocol-error flags.

## Interface

Parameters:
- NPORTS, 5, number of output ports (L, N, E, S, W order; bit 0 = L)
- DEPTH, 4, downstream input-FIFO depth in flits; also the reset credit value; must be ≥1
- CW, $clog2(DEPTH+1), credit counter width (derived; do not override)

Ports:
- clk  in  1  router clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- port_sel  in  NPORTS  one-hot output-port request from LBDR; all-zero means no request
- send  in  NPORTS  flit transferred on output port p this cycle (grant && valid)
- credit_in  in  NPORTS  downstream freed one slot on port p (one-cycle pulse per slot)
- ready_out  out  NPORTS  port p is selected and has ≥1 credit; drives the arbiter
- credit_cnt  out  NPORTS*CW  current credits; port p occupies bits [p*CW +: CW]
- err_underflow  out  NPORTS  sticky: send[p] arrived while credit was 0
- err_overflow  out  NPORTS  sticky: credit_in[p] would exceed DEPTH

## Operation

- There is one independent counter `cnt[p]` per port. Ports never interact.
- `ready_out[p]` = !rst && port_sel[p] && (cnt[p] != 0). This is combinational from the current inputs and the registered count.
- Counter update, per port, on each clock edge when rst = 0:
  - send=1, credit_in=0, cnt>0: cnt − 1
  - send=0, credit_in=1, cnt<DEPTH: cnt + 1
  - send=1, credit_in=1: cnt unchanged. This also applies at cnt=0 and at cnt=DEPTH, and neither error is raised.
  - send=1, credit_in=0, cnt=0: cnt stays 0 (no wrap); set err_underflow[p]
  - send=0, credit_in=1, cnt=DEPTH: cnt stays DEPTH (saturate); set err_overflow[p]
  - neither: hold
- Error flags are sticky. They clear only on rst.
- `send[p]` is not qualified by port_sel or ready_out inside this block. Legality is checked only through the underflow flag.
- A non-one-hot port_sel is passed through bitwise. The block does not check it.

## Timing

- Reset values (at the first edge with rst=1 and held while rst=1): cnt[p]=DEPTH, credit_cnt = DEPTH on every port, err_* = 0. ready_out = 0 combinationally while rst=1, regardless of port_sel.
- Reset mid-operation restores full credits at the next edge. Any send and credit_in pulses present during rst are discarded.
- Latency:
  - port_sel to ready_out: 0 cycles (combinational).
  - send or credit_in to credit_cnt: 1 cycle.
  - send on the last credit drops ready_out in the following cycle. The same cycle is still ready, because the flit consuming that credit is legal.
- A credit returned in cycle t makes ready_out high in cycle t+1, provided port_sel is high.
- Error flags assert in the cycle after the offending edge.
- Continuous throughput: with credit_in and send both asserted every cycle, cnt stays constant and ready_out stays high.

## Test plan

- Reset: hold rst 2 cycles with port_sel=5'b11111 → ready_out=0 during rst. After release, credit_cnt = 4 on all ports and ready_out = 5'b11111.
- Drain: DEPTH=4, port_sel=N, send[N] for 4 consecutive cycles → cnt goes 3, 2, 1, 0. ready_out[N] falls after the 4th send. err_underflow stays 0.
- Underflow: at cnt[E]=0, pulse send[E] → cnt stays 0 and err_underflow[E]=1. It stays 1 after credit_in until rst.
- Overflow and saturation: at cnt[L]=4, pulse credit_in[L] → cnt stays 4 and err_overflow[L]=1. No other port's flags change.
- Simultaneous: at cnt[S]=0, assert send[S] and credit_in[S] together → cnt stays 0 and no error. At cnt=2 with both asserted for 10 cycles → cnt stays 2.
- Mid-op reset: cnt = {1,0,3,2,4}, assert rst for 1 cycle alongside send[all] → all counters read 4 and all error flags 0 on the next cycle.

Source files
------------

// File: rtl/credit_flowcontrol.sv
// Per-port credit counters gating ready_out toward the downstream input FIFOs.
// Each port tracks free downstream slots; send consumes a credit, credit_in returns one.
module credit_flowcontrol #(
  parameter int unsigned NPORTS = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    port_sel,
  input  logic [NPORTS-1:0]    send,
  input  logic [NPORTS-1:0]    credit_in,
  output logic [NPORTS-1:0]    ready_out,
  output logic [NPORTS*CW-1:0] credit_cnt,
  output logic [NPORTS-1:0]    err_underflow,
  output logic [NPORTS-1:0]    err_overflow
);

  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [CW-1:0]     cnt_q [NPORTS];
  logic [CW-1:0]     cnt_d [NPORTS];
  logic [NPORTS-1:0] uf_q, uf_d;
  logic [NPORTS-1:0] of_q, of_d;

  always_comb begin
    uf_d = uf_q;
    of_d = of_q;
    for (int p = 0; p < NPORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      // Simultaneous send and credit_in cancel out, even at the limits.
      if (send[p] && !credit_in[p]) begin
        if (cnt_q[p] != '0) cnt_d[p] = cnt_q[p] - 1'b1;
        else                uf_d[p]  = 1'b1;
      end else if (credit_in[p] && !send[p]) begin
        if (cnt_q[p] != Full) cnt_d[p] = cnt_q[p] + 1'b1;
        else                  of_d[p]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) cnt_q[p] <= Full;
      uf_q <= '0;
      of_q <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) cnt_q[p] <= cnt_d[p];
      uf_q <= uf_d;
      of_q <= of_d;
    end
  end

  always_comb begin
    ready_out  = '0;
    credit_cnt = '0;
    for (int p = 0; p < NPORTS; p++) begin
      ready_out[p]           = !rst && port_sel[p] && (cnt_q[p] != '0);
      credit_cnt[p*CW +: CW] = cnt_q[p];
    end
  end

  assign err_underflow = uf_q;
  assign err_overflow  = of_q;

endmodule

// File: tb/tb_credit_flowcontrol.sv
// Directed, table-driven bench for credit_flowcontrol with NPORTS=5, DEPTH=4.
// Port bits: 0=L, 1=N, 2=E, 3=S, 4=W.
module tb_credit_flowcontrol;

  localparam int unsigned NPORTS = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = 3;

  logic                 clk;
  logic                 rst;
  logic [NPORTS-1:0]    port_sel;
  logic [NPORTS-1:0]    send;
  logic [NPORTS-1:0]    credit_in;
  logic [NPORTS-1:0]    ready_out;
  logic [NPORTS*CW-1:0] credit_cnt;
  logic [NPORTS-1:0]    err_underflow;
  logic [NPORTS-1:0]    err_overflow;

  credit_flowcontrol #(
    .NPORTS(NPORTS),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_sel     (port_sel),
    .send         (send),
    .credit_in    (credit_in),
    .ready_out    (ready_out),
    .credit_cnt   (credit_cnt),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cnt/uf/of are the expected state before the edge that consumes this row's inputs.
  typedef struct {
    logic        rst;
    logic [4:0]  sel;
    logic [4:0]  snd;
    logic [4:0]  cr;
    logic [4:0]  ready;
    logic [14:0] cnt;
    logic [4:0]  uf;
    logic [4:0]  of;
    logic        chk;
  } vec_t;

  vec_t vt [40];
  int   nv;
  int   ntests;
  int   nfail;

  function automatic logic [14:0] pk(int w, int s, int e, int n, int l);
    return {3'(w), 3'(s), 3'(e), 3'(n), 3'(l)};
  endfunction

  task automatic add(logic r, logic [4:0] sel, logic [4:0] snd, logic [4:0] cr,
                     logic [4:0] rdy, logic [14:0] cnt, logic [4:0] uf, logic [4:0] of,
                     logic chk);
    vt[nv] = '{rst: r, sel: sel, snd: snd, cr: cr, ready: rdy, cnt: cnt, uf: uf, of: of,
               chk: chk};
    nv++;
  endtask

  task automatic cmp(string name, int idx, logic [14:0] act, logic [14:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [4:0] sel, logic [4:0] snd, logic [4:0] cr);
    rst       = r;
    port_sel  = sel;
    send      = snd;
    credit_in = cr;
  endtask

  // Inputs are driven just after a rising edge and outputs checked on the falling edge.
  task automatic run_rows(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      drive(vt[i].rst, vt[i].sel, vt[i].snd, vt[i].cr);
      @(negedge clk);
      cmp("ready_out", i, 15'(ready_out), 15'(vt[i].ready));
      if (vt[i].chk) begin
        cmp("credit_cnt", i, credit_cnt, vt[i].cnt);
        cmp("err_underflow", i, 15'(err_underflow), 15'(vt[i].uf));
        cmp("err_overflow", i, 15'(err_overflow), 15'(vt[i].of));
      end
      @(posedge clk);
      #1;
    end
  endtask

  int split;

  initial begin
    ntests = 0;
    nfail  = 0;
    nv     = 0;
    //   rst  sel       send      credit    ready     cnt(W,S,E,N,L)  uf        of        chk
    // Reset held two cycles with all ports selected
    add(1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, pk(4,4,4,4,4), 5'b00000, 5'b00000, 0);
    add(1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, pk(4,4,4,4,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b11111, 5'b00000, 5'b00000, 5'b11111, pk(4,4,4,4,4), 5'b00000, 5'b00000, 1);
    // Drain N: last send is still ready, then ready drops
    add(0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, pk(4,4,4,4,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, pk(4,4,4,3,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, pk(4,4,4,2,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, pk(4,4,4,1,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, pk(4,4,4,0,4), 5'b00000, 5'b00000, 1);
    // Drain E then underflow it; flag survives a returned credit
    add(0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, pk(4,4,4,0,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, pk(4,4,3,0,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, pk(4,4,2,0,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, pk(4,4,1,0,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00100, 5'b00100, 5'b00000, 5'b00000, pk(4,4,0,0,4), 5'b00000, 5'b00000, 1);
    add(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, pk(4,4,0,0,4), 5'b00100, 5'b00000, 1);
    add(0, 5'b00100, 5'b00000, 5'b00000, 5'b00100, pk(4,4,1,0,4), 5'b00100, 5'b00000, 1);
    // Overflow L at full credit: saturates, only L flag set
    add(0, 5'b00001, 5'b00000, 5'b00001, 5'b00001, pk(4,4,1,0,4), 5'b00100, 5'b00000, 1);
    add(0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, pk(4,4,1,0,4), 5'b00100, 5'b00001, 1);
    // Unselected sends on S still consume credits
    add(0, 5'b00000, 5'b01000, 5'b00000, 5'b00000, pk(4,4,1,0,4), 5'b00100, 5'b00001, 1);
    add(0, 5'b00000, 5'b01000, 5'b00000, 5'b00000, pk(4,3,1,0,4), 5'b00100, 5'b00001, 1);
    add(0, 5'b00000, 5'b01000, 5'b00000, 5'b00000, pk(4,2,1,0,4), 5'b00100, 5'b00001, 1);
    add(0, 5'b00000, 5'b01000, 5'b00000, 5'b00000, pk(4,1,1,0,4), 5'b00100, 5'b00001, 1);
    // Send and credit together at zero: no change, no error
    add(0, 5'b01000, 5'b01000, 5'b01000, 5'b00000, pk(4,0,1,0,4), 5'b00100, 5'b00001, 1);
    add(0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, pk(4,0,1,0,4), 5'b00100, 5'b00001, 1);
    // Refill N to 2; returned credit makes ready the next cycle
    add(0, 5'b00010, 5'b00000, 5'b00010, 5'b00000, pk(4,0,1,0,4), 5'b00100, 5'b00001, 1);
    add(0, 5'b00010, 5'b00000, 5'b00010, 5'b00010, pk(4,0,1,1,4), 5'b00100, 5'b00001, 1);
    split = nv;
    // Build cnt L..W = 1,0,3,2,4, then reset with sends on every port
    add(0, 5'b00000, 5'b00011, 5'b01100, 5'b00000, pk(4,0,1,2,4), 5'b00100, 5'b00001, 1);
    add(0, 5'b00000, 5'b00011, 5'b01100, 5'b00000, pk(4,1,2,1,3), 5'b00100, 5'b00001, 1);
    add(0, 5'b11111, 5'b00001, 5'b00000, 5'b11101, pk(4,2,3,0,2), 5'b00100, 5'b00001, 1);
    add(1, 5'b11111, 5'b11111, 5'b00000, 5'b00000, pk(4,2,3,0,1), 5'b00100, 5'b00001, 1);
    add(0, 5'b11111, 5'b00000, 5'b00000, 5'b11111, pk(4,4,4,4,4), 5'b00000, 5'b00000, 1);

    drive(1'b1, 5'b11111, 5'b00000, 5'b00000);
    run_rows(0, split);

    // Continuous throughput on N at cnt=2: count and ready hold for 10 cycles
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 5'b00010, 5'b00010, 5'b00010);
      @(negedge clk);
      cmp("thru_cnt", k, credit_cnt, pk(4,0,1,2,4));
      cmp("thru_ready", k, 15'(ready_out), 15'(5'b00010));
      cmp("thru_uf", k, 15'(err_underflow), 15'(5'b00100));
      @(posedge clk);
      #1;
    end

    run_rows(split, nv);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
